datapath_ctrl: RTL

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

---
 rtl/datapath_ctrl_pkg.sv | 32 +++
 rtl/datapath_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared types and constants for the gamma-LUT reload / parameter-shadow
// controller (datapath_ctrl).
//   PADDR / PDATA   : LUT address / data widths
//   cp_param_t      : colour-processing parameter word
//   color_signed_t  : signed brightness offset
//   state_t         : controller FSM states
//   FLUSH_CYCLES    : length of the datapath reset pulse after a reload
//   WDOG_*          : LOAD stall watchdog (used only with LOAD_TIMEOUT_EN)
package datapath_ctrl_pkg;

  localparam int PADDR = 8;
  localparam int PDATA = 8;

  typedef logic [7:0]        cp_param_t;
  typedef logic signed [7:0] color_signed_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    LOAD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int FLUSH_CYCLES = 3;
  localparam int FLUSH_W      = $clog2(FLUSH_CYCLES);

  localparam logic [PADDR-1:0] LAST_ADDR = '1;

  localparam int               WDOG_W     = 10;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = '1;

endpackage

// File: rtl/datapath_ctrl.sv
// Gamma-LUT reload sequencer and frame-synchronous parameter shadowing.
//
// A load_req pulse in IDLE clears the parameter block for one cycle, streams
// 256 LUT entries (ascending address) into the LUT write port, then holds the
// datapath in reset for FLUSH_CYCLES before returning to IDLE with load_done.
// Shadow parameters are copied to the active outputs only on frame_start in
// IDLE; a frame_start while busy is remembered and applied on the first IDLE
// cycle.
//
// Optional feature: define LOAD_TIMEOUT_EN to enable a 10-bit LOAD stall
// watchdog; on expiry load_err is set (sticky until the next accepted
// load_req), the load is abandoned through FLUSH and load_done is suppressed.
//
// Ports
//   clk, resetN                    clock, async active-low reset
//   load_req                       start LUT reload (honoured in IDLE only)
//   lut_data_valid/lut_data/ready  LUT entry stream
//   frame_start, downstream_ready  frame boundary pulse, sink readiness
//   en_shadow {g,c,b}, cp_param_shadow, brightness_shadow   software values
//   g_en/c_en/b_en, cp_param, brightness_param              active values
//   glut_write_en_n, glut_from, glut_to                     LUT write port
//   params_resetN, datapath_resetN  low during CLR / FLUSH respectively
//   datapath_ready, busy, load_done, load_err               status
//
// state | meaning
// IDLE  | waiting; parameter copies allowed
// CLR   | one-cycle parameter block clear, address counter to 0
// LOAD  | accepting LUT entries, one write per valid beat
// FLUSH | datapath held in reset for FLUSH_CYCLES
module datapath_ctrl
  import datapath_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              resetN,
  input  logic              load_req,
  input  logic              lut_data_valid,
  input  logic [PDATA-1:0]  lut_data,
  output logic              lut_data_ready,
  input  logic              frame_start,
  input  logic              downstream_ready,
  input  logic [2:0]        en_shadow,
  input  cp_param_t         cp_param_shadow,
  input  color_signed_t     brightness_shadow,
  output logic              g_en,
  output logic              c_en,
  output logic              b_en,
  output cp_param_t         cp_param,
  output color_signed_t     brightness_param,
  output logic              glut_write_en_n,
  output logic [PADDR-1:0]  glut_from,
  output logic [PDATA-1:0]  glut_to,
  output logic              params_resetN,
  output logic              datapath_resetN,
  output logic              datapath_ready,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  state_t              state;
  logic [PADDR-1:0]    addr;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic                copy_pend;
  logic                wr;
  logic                end_load;
`ifdef LOAD_TIMEOUT_EN
  logic [WDOG_W-1:0]   wdog;
  logic                err;
  logic                wdog_trip;
`endif

  // lut_data_ready is a registered copy of (state == LOAD), so the handshake
  // reduces to valid while in LOAD.
  assign wr              = (state == LOAD) && lut_data_valid;
  assign glut_write_en_n = ~wr;
  assign glut_from       = addr;
  assign glut_to         = lut_data;

  assign busy            = (state != IDLE);
  assign datapath_ready  = downstream_ready && (state == IDLE);

`ifdef LOAD_TIMEOUT_EN
  // Trips on the 1023rd consecutive stall cycle.
  assign wdog_trip = (state == LOAD) && !lut_data_valid && (wdog == WDOG_LIMIT - 1'b1);
  assign end_load  = (wr && (addr == LAST_ADDR)) || wdog_trip;
  assign load_err  = err;
`else
  assign end_load  = wr && (addr == LAST_ADDR);
  assign load_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= IDLE;
      addr            <= '0;
      flush_cnt       <= '0;
      params_resetN   <= 1'b1;
      datapath_resetN <= 1'b1;
      lut_data_ready  <= 1'b0;
      load_done       <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      wdog            <= '0;
      err             <= 1'b0;
`endif
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_req) begin
            state         <= CLR;
            params_resetN <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            err           <= 1'b0;
`endif
          end
        end
        CLR: begin
          state          <= LOAD;
          params_resetN  <= 1'b1;
          lut_data_ready <= 1'b1;
          addr           <= '0;
`ifdef LOAD_TIMEOUT_EN
          wdog           <= '0;
`endif
        end
        LOAD: begin
          // addr wraps 255 -> 0 on the final write
          if (wr) begin
            addr <= addr + 1'b1;
`ifdef LOAD_TIMEOUT_EN
            wdog <= '0;
          end else begin
            wdog <= wdog + 1'b1;
`endif
          end
          if (end_load) begin
            state           <= FLUSH;
            lut_data_ready  <= 1'b0;
            datapath_resetN <= 1'b0;
            flush_cnt       <= FLUSH_W'(FLUSH_CYCLES - 1);
          end
`ifdef LOAD_TIMEOUT_EN
          if (wdog_trip) err <= 1'b1;
`endif
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state           <= IDLE;
            datapath_resetN <= 1'b1;
`ifdef LOAD_TIMEOUT_EN
            load_done       <= ~err;
`else
            load_done       <= 1'b1;
`endif
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Active parameters only change at frame boundaries while IDLE; any number
  // of frame_start pulses during a busy period collapse into one copy.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      copy_pend        <= 1'b0;
      g_en             <= 1'b0;
      c_en             <= 1'b0;
      b_en             <= 1'b0;
      cp_param         <= '0;
      brightness_param <= '0;
    end else if (state == IDLE) begin
      if (frame_start || copy_pend) begin
        {g_en, c_en, b_en} <= en_shadow;
        cp_param           <= cp_param_shadow;
        brightness_param   <= brightness_shadow;
        copy_pend          <= 1'b0;
      end
    end else if (frame_start) begin
      copy_pend <= 1'b1;
    end
  end

endmodule
